// File: rtl/pc_queue_sequencer.sv
// pc_queue_sequencer
// Front/back PC queue (IAOQ) that feeds fetch and target-address generation.
// f_pc is the fetch address and b_pc is the next-to-issue address. The queue
// advances one slot on every unstalled cycle. A taken branch redirects b_pc
// to the target ta. f_pc then picks up ta one cycle later, which produces the
// single PA-RISC delay slot.
// Optional feature macro: DELAY_SLOT_NULLIFY_EN (branch ,n completer support).
module pc_queue_sequencer #(
    parameter int PC_W     = 8,
    parameter int INC      = 4,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] ta,
    input  logic            nullify_in,
    output logic [PC_W-1:0] f_pc_o,
    output logic [PC_W-1:0] b_pc_o,
    output logic            in_slot_o,
    output logic            slot_null_o,
    output logic            slot_branch_err_o
);

    localparam logic [PC_W-1:0] INC_V     = PC_W'(INC);
    localparam logic [PC_W-1:0] RESET_F   = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] RESET_B   = PC_W'(RESET_PC + INC);

    typedef enum logic {
        SEQ  = 1'b0,
        SLOT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] f_pc_q, f_pc_d;
    logic [PC_W-1:0] b_pc_q, b_pc_d;
    logic            slot_null_q, slot_null_d;
    logic            err_q, err_d;
    logic            advance;
    logic            take;
    logic            nullify_sel;

    assign advance = !stall;
    assign take    = branch_taken && (state_q == SEQ);

`ifdef DELAY_SLOT_NULLIFY_EN
    assign nullify_sel = nullify_in;
`else
    logic unused_nullify;
    assign unused_nullify = nullify_in;
    assign nullify_sel    = 1'b0;
`endif

    // Next-state logic: the PC queue shift, branch redirect, slot tracking and the error pulse.
    always_comb begin
        state_d     = state_q;
        f_pc_d      = f_pc_q;
        b_pc_d      = b_pc_q;
        slot_null_d = slot_null_q;
        err_d       = 1'b0;
        if (advance) begin
            f_pc_d = b_pc_q;
            if (take) begin
                b_pc_d      = ta;
                state_d     = SLOT;
                slot_null_d = nullify_sel;
            end else begin
                b_pc_d = b_pc_q + INC_V;
            end
            if (state_q == SLOT) begin
                state_d     = SEQ;
                slot_null_d = 1'b0;
                err_d       = branch_taken && !slot_null_q;
            end
        end
    end

    // State and registered outputs; reset takes effect immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SEQ;
            f_pc_q      <= RESET_F;
            b_pc_q      <= RESET_B;
            slot_null_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            f_pc_q      <= f_pc_d;
            b_pc_q      <= b_pc_d;
            slot_null_q <= slot_null_d;
            err_q       <= err_d;
        end
    end

    assign f_pc_o            = f_pc_q;
    assign b_pc_o            = b_pc_q;
    assign in_slot_o         = (state_q == SLOT);
    assign slot_null_o       = slot_null_q;
    assign slot_branch_err_o = err_q;

endmodule

// File: tb/tb_pc_queue_sequencer.sv
// Testbench for pc_queue_sequencer: directed vectors with literal expectations
// plus a behavioural model compared against the DUT on every falling edge.
module tb_pc_queue_sequencer;

    logic       clk;
    logic       reset;
    logic       stall;
    logic       branch_taken;
    logic [7:0] ta;
    logic       nullify_in;
    logic [7:0] f_pc_o;
    logic [7:0] b_pc_o;
    logic       in_slot_o;
    logic       slot_null_o;
    logic       slot_branch_err_o;

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 0;

`ifdef DELAY_SLOT_NULLIFY_EN
    localparam bit NULL_EN = 1'b1;
`else
    localparam bit NULL_EN = 1'b0;
`endif

    pc_queue_sequencer #(.PC_W(8), .INC(4), .RESET_PC(0)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .ta               (ta),
        .nullify_in       (nullify_in),
        .f_pc_o           (f_pc_o),
        .b_pc_o           (b_pc_o),
        .in_slot_o        (in_slot_o),
        .slot_null_o      (slot_null_o),
        .slot_branch_err_o(slot_branch_err_o)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the fetch address is the previously issued address,
    // the next address is sequential or the branch target, and a taken
    // branch opens exactly one delay slot in which further branches are refused.
    logic [7:0] m_f, m_b;
    bit         m_slot, m_null, m_err;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_f    = 8'h00;
            m_b    = 8'h04;
            m_slot = 0;
            m_null = 0;
            m_err  = 0;
        end else begin
            m_err = 0;
            if (!stall) begin
                m_f = m_b;
                if (m_slot) begin
                    m_err  = branch_taken && !m_null;
                    m_b    = m_b + 8'd4;
                    m_slot = 0;
                    m_null = 0;
                end else if (branch_taken) begin
                    m_b    = ta;
                    m_slot = 1;
                    m_null = NULL_EN && nullify_in;
                end else begin
                    m_b = m_b + 8'd4;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("model f_pc", f_pc_o, m_f);
            checkOutput("model b_pc", b_pc_o, m_b);
            checkOutput("model in_slot", {7'd0, in_slot_o}, {7'd0, m_slot});
            checkOutput("model slot_null", {7'd0, slot_null_o}, {7'd0, m_null});
            checkOutput("model slot_err", {7'd0, slot_branch_err_o}, {7'd0, m_err});
        end
    end

    // Drive one cycle of inputs, then return 2 time units after the edge.
    task automatic applyStimulus(input bit s, input bit br, input logic [7:0] t, input bit n);
        stall        = s;
        branch_taken = br;
        ta           = t;
        nullify_in   = n;
        @(posedge clk);
        #2;
    endtask

    task automatic checkState(input string tag, input logic [7:0] f, input logic [7:0] b,
                              input bit slot, input bit nul, input bit err);
        checkOutput({tag, " f_pc"}, f_pc_o, f);
        checkOutput({tag, " b_pc"}, b_pc_o, b);
        checkOutput({tag, " in_slot"}, {7'd0, in_slot_o}, {7'd0, slot});
        checkOutput({tag, " slot_null"}, {7'd0, slot_null_o}, {7'd0, nul});
        checkOutput({tag, " slot_err"}, {7'd0, slot_branch_err_o}, {7'd0, err});
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        checkState("reset async", 8'h00, 8'h04, 0, 0, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        checkState("reset", 8'h00, 8'h04, 0, 0, 0);
    endtask

    initial begin
        reset        = 1'b1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        ta           = 8'h00;
        nullify_in   = 1'b0;
        @(posedge clk);
        #2;
        doReset();
        chk_en = 1;

        // Sequential fetch.
        applyStimulus(0, 0, 8'h00, 0); checkState("seq1", 8'h04, 8'h08, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0); checkState("seq2", 8'h08, 8'h0C, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0); checkState("seq3", 8'h0C, 8'h10, 0, 0, 0);

        // Taken branch from b_pc=08.
        doReset();
        applyStimulus(0, 0, 8'h00, 0); checkState("pre br", 8'h04, 8'h08, 0, 0, 0);
        applyStimulus(0, 1, 8'h40, 0); checkState("br", 8'h08, 8'h40, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 0); checkState("br+1", 8'h40, 8'h44, 0, 0, 0);

        // Stalled branch, released with the branch held.
        doReset();
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(1, 1, 8'h40, 0); checkState("stall br", 8'h04, 8'h08, 0, 0, 0);
        applyStimulus(0, 1, 8'h40, 0); checkState("release br", 8'h08, 8'h40, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 0); checkState("release+1", 8'h40, 8'h44, 0, 0, 0);

        // Branch in delay slot is refused and flagged.
        applyStimulus(0, 1, 8'h60, 0); checkState("br2", 8'h44, 8'h60, 1, 0, 0);
        applyStimulus(0, 1, 8'h80, 0); checkState("slot br", 8'h60, 8'h64, 0, 0, 1);
        applyStimulus(0, 0, 8'h00, 0); checkState("slot br+1", 8'h64, 8'h68, 0, 0, 0);

        // Slot holds across a stall.
        applyStimulus(0, 1, 8'hA0, 0); checkState("br3", 8'h68, 8'hA0, 1, 0, 0);
        applyStimulus(1, 1, 8'h80, 0); checkState("slot stall", 8'h68, 8'hA0, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 0); checkState("slot exit", 8'hA0, 8'hA4, 0, 0, 0);

        // Wrap of sequential increment and high target.
        applyStimulus(0, 1, 8'hFC, 0); checkState("br FC", 8'hA4, 8'hFC, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 0); checkState("wrap", 8'hFC, 8'h00, 0, 0, 0);
        applyStimulus(0, 1, 8'h0C, 0); checkState("br 0C", 8'h00, 8'h0C, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 0); checkState("at 10", 8'h0C, 8'h10, 0, 0, 0);
        applyStimulus(0, 1, 8'hF0, 0); checkState("br F0", 8'h10, 8'hF0, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 0); checkState("F0+1", 8'hF0, 8'hF4, 0, 0, 0);

        // Target equal to the sequential address still opens a slot.
        applyStimulus(0, 1, 8'hF8, 0); checkState("br seq", 8'hF4, 8'hF8, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 0); checkState("br seq+1", 8'hF8, 8'hFC, 0, 0, 0);

        // Nullified slot, branch inside it, then asynchronous reset mid-slot.
        applyStimulus(0, 1, 8'h20, 1); checkState("br n", 8'hFC, 8'h20, 1, NULL_EN, 0);
        applyStimulus(0, 1, 8'h80, 0); checkState("null slot br", 8'h20, 8'h24, 0, 0, !NULL_EN);
        applyStimulus(0, 1, 8'h30, 1); checkState("br n2", 8'h24, 8'h30, 1, NULL_EN, 0);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 1, 8'h50, 1); checkState("br n3", 8'h34, 8'h50, 1, NULL_EN, 0);
        doReset();
        applyStimulus(0, 0, 8'h00, 0); checkState("post reset", 8'h04, 8'h08, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
